// File: rtl/ccip_tx_flow_scheduler.sv
// Round-robin TX flow scheduler for CCI-P write-back: grants one flow at a time
// (full batch or timed-out partial flush) and holds it until the datapath signals completion.
module ccip_tx_flow_scheduler #(
   parameter int NIC_ID            = 0,
   parameter int LMAX_NUM_OF_FLOWS = 1,
   parameter int LOCC_WIDTH        = 4,
   parameter int TIMEOUT_WIDTH     = 16
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            enable,
   input  logic [LMAX_NUM_OF_FLOWS-1:0]                    number_of_flows,
   input  logic [1:0]                                      l_batch_size,
   input  logic [TIMEOUT_WIDTH-1:0]                        flush_timeout,
   input  logic [(2**LMAX_NUM_OF_FLOWS)*LOCC_WIDTH-1:0]    flow_occupancy,
   input  logic                                            c1_alm_full,
   output logic                                            sched_valid,
   input  logic                                            sched_ready,
   output logic [LMAX_NUM_OF_FLOWS-1:0]                    sched_flow_id,
   output logic [2:0]                                      sched_batch_len,
   output logic                                            sched_is_flush,
   input  logic                                            tx_done,
   output logic                                            busy,
   output logic [31:0]                                     flush_count
);

   localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;

   typedef logic [LMAX_NUM_OF_FLOWS-1:0] fid_t;
   typedef enum logic [1:0] {SCAN, GRANT, WAIT_DONE} state_t;

   // NIC_ID only tags simulation messages; no hardware depends on it.
   if (NIC_ID < 0) begin : g_nic_id_unused
   end

   state_t                                     state_q, state_d;
   fid_t                                       ptr_q, ptr_d, flow_q, flow_d;
   logic                                       valid_q, valid_d, flush_q, flush_d;
   logic [2:0]                                 len_q, len_d;
   logic [31:0]                                fcnt_q, fcnt_d;
   logic [MAX_FLOWS-1:0][TIMEOUT_WIDTH-1:0]    age_q, age_d;
   logic [MAX_FLOWS-1:0][LOCC_WIDTH-1:0]       occ;
   logic [MAX_FLOWS-1:0]                       active, is_full, is_aged;
   logic [2:0]                                 bsize;
   logic                                       handshake;

   assign occ       = flow_occupancy;
   assign handshake = valid_q && sched_ready;

   function automatic fid_t wrap(input fid_t p);
      return (p >= number_of_flows) ? '0 : fid_t'(p + 1'b1);
   endfunction

   always_comb begin
      bsize = l_batch_size[1] ? 3'd4 : (l_batch_size[0] ? 3'd2 : 3'd1);
      for (int f = 0; f < MAX_FLOWS; f++) begin
         active[f]  = fid_t'(f) <= number_of_flows;
         is_full[f] = 32'(occ[f]) >= 32'(bsize);
         is_aged[f] = (flush_timeout != '0) && (age_q[f] >= flush_timeout) && (occ[f] != '0);
      end
   end

   // Ages only count while a flow sits on a partial batch; a grant of that flow restarts it.
   always_comb begin
      for (int f = 0; f < MAX_FLOWS; f++) begin
         age_d[f] = '0;
         if (active[f] && occ[f] != '0 && !is_full[f])
            age_d[f] = (age_q[f] == '1) ? age_q[f] : age_q[f] + 1'b1;
         if (handshake && flow_q == fid_t'(f))
            age_d[f] = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      flow_d  = flow_q;
      len_d   = len_q;
      flush_d = flush_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         SCAN: begin
            if (ptr_q > number_of_flows) begin
               ptr_d = '0;
            end else if (enable && !c1_alm_full && active[ptr_q] &&
                         (is_full[ptr_q] || is_aged[ptr_q])) begin
               state_d = GRANT;
               valid_d = 1'b1;
               flow_d  = ptr_q;
               flush_d = !is_full[ptr_q];
               len_d   = is_full[ptr_q] ? bsize : 3'(occ[ptr_q]);
            end else if (!c1_alm_full) begin
               ptr_d = wrap(ptr_q);
            end
         end
         GRANT: begin
            if (sched_ready) begin
               state_d = WAIT_DONE;
               valid_d = 1'b0;
               ptr_d   = wrap(ptr_q);
               if (flush_q) fcnt_d = fcnt_q + 32'd1;
            end
         end
         WAIT_DONE: begin
            if (tx_done) state_d = SCAN;
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SCAN;
         ptr_q   <= '0;
         flow_q  <= '0;
         valid_q <= 1'b0;
         flush_q <= 1'b0;
         len_q   <= '0;
         fcnt_q  <= '0;
         age_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         flow_q  <= flow_d;
         valid_q <= valid_d;
         flush_q <= flush_d;
         len_q   <= len_d;
         fcnt_q  <= fcnt_d;
         age_q   <= age_d;
      end
   end

   assign sched_valid     = valid_q;
   assign sched_flow_id   = flow_q;
   assign sched_batch_len = len_q;
   assign sched_is_flush  = flush_q;
   assign busy            = (state_q != SCAN);
   assign flush_count     = fcnt_q;

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// Bench for ccip_tx_flow_scheduler: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the scheduling rules.
module tb_ccip_tx_flow_scheduler;
   localparam int LF = 2, LW = 4, TW = 4, MF = 4, AMAX = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, enable, c1_alm_full, sched_ready, tx_done;
   logic [LF-1:0]     number_of_flows;
   logic [1:0]        l_batch_size;
   logic [TW-1:0]     flush_timeout;
   logic [MF*LW-1:0]  flow_occupancy;
   logic              sched_valid, sched_is_flush, busy;
   logic [LF-1:0]     sched_flow_id;
   logic [2:0]        sched_batch_len;
   logic [31:0]       flush_count;

   ccip_tx_flow_scheduler #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF), .LOCC_WIDTH(LW), .TIMEOUT_WIDTH(TW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .number_of_flows(number_of_flows),
      .l_batch_size(l_batch_size), .flush_timeout(flush_timeout), .flow_occupancy(flow_occupancy),
      .c1_alm_full(c1_alm_full), .sched_valid(sched_valid), .sched_ready(sched_ready),
      .sched_flow_id(sched_flow_id), .sched_batch_len(sched_batch_len), .sched_is_flush(sched_is_flush),
      .tx_done(tx_done), .busy(busy), .flush_count(flush_count));

   int vecs = 0, errs = 0;

   // Reference model: one outstanding grant, a waiting-for-done flag, a scan position, ages.
   bit        m_valid, m_wait, m_flush, m_acc;
   int        m_flow, m_len, m_ptr;
   int        m_age[MF];
   bit [31:0] m_fcnt;

   wire [39:0] dut_vec = {sched_valid, sched_flow_id, sched_batch_len, sched_is_flush, busy, flush_count};

   function automatic logic [39:0] exp_vec();
      return {m_valid, LF'(m_flow), 3'(m_len), m_flush, (m_valid | m_wait), m_fcnt};
   endfunction

   function automatic int occ_of(int f);
      return int'(flow_occupancy[f*LW +: LW]);
   endfunction

   function automatic logic [MF*LW-1:0] pack(int a, int b, int c, int d);
      return {LW'(d), LW'(c), LW'(b), LW'(a)};
   endfunction

   // Advance model and DUT by one clock; DUT outputs are sampled 1ns after the edge.
   task automatic tick();
      int b, nof, o;
      int nage[MF];
      bit full, aged;
      nof   = int'(number_of_flows);
      b     = 1 << ((l_batch_size > 2) ? 2 : int'(l_batch_size));
      m_acc = 0;
      if (reset) begin
         m_valid = 0; m_wait = 0; m_flush = 0; m_flow = 0; m_len = 0; m_ptr = 0; m_fcnt = 0;
         for (int f = 0; f < MF; f++) m_age[f] = 0;
      end else begin
         for (int f = 0; f < MF; f++) begin
            o = occ_of(f);
            if (f > nof || o == 0 || o >= b) nage[f] = 0;
            else nage[f] = (m_age[f] >= AMAX) ? AMAX : m_age[f] + 1;
            if (m_valid && sched_ready && f == m_flow) nage[f] = 0;
         end
         if (m_valid) begin
            if (sched_ready) begin
               m_valid = 0; m_wait = 1; m_acc = 1;
               if (m_flush) m_fcnt = m_fcnt + 1;
               m_ptr = (m_ptr >= nof) ? 0 : m_ptr + 1;
            end
         end else if (m_wait) begin
            if (tx_done) m_wait = 0;
         end else if (m_ptr > nof) begin
            m_ptr = 0;
         end else begin
            o    = occ_of(m_ptr);
            full = (o >= b);
            aged = (flush_timeout != 0) && (m_age[m_ptr] >= int'(flush_timeout)) && (o > 0);
            if (enable && !c1_alm_full && (full || aged)) begin
               m_valid = 1; m_flow = m_ptr; m_flush = !full; m_len = full ? b : o;
            end else if (!c1_alm_full) begin
               m_ptr = (m_ptr >= nof) ? 0 : m_ptr + 1;
            end
         end
         for (int f = 0; f < MF; f++) m_age[f] = nage[f];
      end
      @(posedge clk); #1;
   endtask

   task automatic set_idle();
      enable = 1'b1; c1_alm_full = 1'b0; sched_ready = 1'b0; tx_done = 1'b0;
      number_of_flows = 2'd1; l_batch_size = 2'd2; flush_timeout = '0; flow_occupancy = '0;
   endtask

   task automatic do_reset();
      set_idle();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; set_idle(); tick(); tick();
      vecs++;
      if (dut_vec !== 40'd0) begin errs++; $display("FAIL reset_state got=%h exp=0", dut_vec); end
      reset = 1'b0;
   endtask

   task automatic test_full_batch();
      int g1 = 0, cd = 0;
      do_reset();
      sched_ready = 1'b1; flow_occupancy = pack(4, 0, 0, 0);
      tick();
      vecs++;
      if ({sched_valid, sched_flow_id, sched_batch_len, sched_is_flush} !== {1'b1, 2'd0, 3'd4, 1'b0}) begin
         errs++; $display("FAIL full_first_grant got=%b exp=1_00_100_0",
                          {sched_valid, sched_flow_id, sched_batch_len, sched_is_flush});
      end
      for (int i = 0; i < 20; i++) begin
         tx_done = 1'b0;
         if (cd > 0) begin cd--; if (cd == 0) tx_done = 1'b1; end
         if (sched_valid && sched_ready && sched_flow_id != 2'd0) g1++;
         tick();
         if (m_acc) cd = 2;
         vecs++;
         if (dut_vec !== exp_vec()) begin errs++; $display("FAIL full_cyc%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      end
      vecs++;
      if (g1 !== 0) begin errs++; $display("FAIL full_empty_flow_granted got=%0d exp=0", g1); end
   endtask

   task automatic test_round_robin();
      int q[$];
      int cd = 0;
      do_reset();
      sched_ready = 1'b1; flow_occupancy = pack(4, 4, 0, 0);
      for (int i = 0; i < 30; i++) begin
         tx_done = 1'b0;
         if (cd > 0) begin cd--; if (cd == 0) tx_done = 1'b1; end
         if (sched_valid && sched_ready) q.push_back(int'(sched_flow_id));
         tick();
         if (m_acc) cd = 2;
         vecs++;
         if (dut_vec !== exp_vec()) begin errs++; $display("FAIL rr_cyc%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      end
      vecs++;
      if (q.size() < 4) begin
         errs++; $display("FAIL rr_grant_count got=%0d exp>=4", q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vecs++;
            if (q[i] !== i % 2) begin errs++; $display("FAIL rr_order%0d got=%0d exp=%0d", i, q[i], i % 2); end
         end
      end
   endtask

   task automatic test_flush();
      int nv = 0;
      do_reset();
      sched_ready = 1'b1; flow_occupancy = pack(2, 0, 0, 0); flush_timeout = 4'd10;
      // age reaches 10 after edge 10; flow 0 is scanned on odd edges, so edge 11 grants
      for (int k = 1; k <= 11; k++) begin
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin errs++; $display("FAIL flush_cyc%0d got=%h exp=%h", k, dut_vec, exp_vec()); end
         if (k < 11 && sched_valid) nv++;
      end
      vecs++;
      if ({sched_valid, sched_flow_id, sched_batch_len, sched_is_flush} !== {1'b1, 2'd0, 3'd2, 1'b1} || nv != 0) begin
         errs++; $display("FAIL flush_grant_timing got=%b early=%0d exp=1_00_010_1 early=0",
                          {sched_valid, sched_flow_id, sched_batch_len, sched_is_flush}, nv);
      end
      tick();
      vecs++;
      if (flush_count !== 32'd1) begin errs++; $display("FAIL flush_count got=%0d exp=1", flush_count); end
      do_reset();
      sched_ready = 1'b1; flow_occupancy = pack(2, 0, 0, 0); flush_timeout = 4'd0;
      nv = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (sched_valid) nv++;
      end
      vecs++;
      if (nv !== 0 || dut_vec !== exp_vec()) begin errs++; $display("FAIL flush_disabled valids=%0d exp=0", nv); end
   endtask

   task automatic test_alm_full();
      int nv = 0;
      do_reset();
      flow_occupancy = pack(4, 4, 0, 0); c1_alm_full = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (sched_valid) nv++;
      end
      vecs++;
      if (nv !== 0) begin errs++; $display("FAIL almfull_valid got=%0d exp=0", nv); end
      c1_alm_full = 1'b0;
      tick();
      vecs++;
      if ({sched_valid, sched_flow_id} !== {1'b1, 2'd0} || dut_vec !== exp_vec()) begin
         errs++; $display("FAIL almfull_release got=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_back_to_back_hold();
      logic [5:0] cap;
      int bound = 0;
      do_reset();
      flow_occupancy = pack(4, 0, 0, 0);
      tick();
      cap = {sched_flow_id, sched_batch_len, sched_is_flush};
      for (int k = 0; k < 5; k++) begin
         flow_occupancy = MF*LW'($urandom); l_batch_size = 2'($urandom);
         enable = 1'($urandom); c1_alm_full = 1'($urandom);
         tick();
         vecs++;
         if (!sched_valid || {sched_flow_id, sched_batch_len, sched_is_flush} !== cap || dut_vec !== exp_vec()) begin
            errs++; $display("FAIL hold_cyc%0d got=%h exp=%h", k, dut_vec, exp_vec());
         end
      end
      set_idle(); sched_ready = 1'b1;
      tick();
      vecs++;
      if ({sched_valid, busy} !== 2'b01) begin errs++; $display("FAIL hold_accept got=%b exp=01", {sched_valid, busy}); end
      sched_ready = 1'b0; tx_done = 1'b1; tick(); tx_done = 1'b0; tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
      vecs++;
      if (busy !== 1'b0 || dut_vec !== exp_vec()) begin errs++; $display("FAIL done_in_scan got=%h exp=%h", dut_vec, exp_vec()); end
      flow_occupancy = pack(4, 0, 0, 0);
      while (!sched_valid && bound < 6) begin tick(); bound++; end
      sched_ready = 1'b1; tick(); sched_ready = 1'b0; tick();
      vecs++;
      if ({sched_valid, busy} !== 2'b01 || dut_vec !== exp_vec()) begin
         errs++; $display("FAIL stale_done got=%h exp=%h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_reset_midgrant();
      int bound = 0;
      do_reset();
      flow_occupancy = pack(0, 4, 0, 0);
      tick(); tick();
      vecs++;
      if ({sched_valid, sched_flow_id} !== {1'b1, 2'd1}) begin
         errs++; $display("FAIL rst_setup_grant got=%b exp=101", {sched_valid, sched_flow_id});
      end
      reset = 1'b1; tick(); reset = 1'b0;
      vecs++;
      if (dut_vec !== 40'd0) begin errs++; $display("FAIL rst_in_grant got=%h exp=0", dut_vec); end
      flow_occupancy = pack(4, 4, 0, 0);
      tick();
      vecs++;
      if ({sched_valid, sched_flow_id} !== {1'b1, 2'd0}) begin
         errs++; $display("FAIL rst_ptr_zero got=%b exp=100", {sched_valid, sched_flow_id});
      end
      do_reset();
      flow_occupancy = pack(2, 0, 0, 0); flush_timeout = 4'd1; sched_ready = 1'b1;
      while (!(busy && !sched_valid) && bound < 10) begin tick(); bound++; end
      vecs++;
      if (flush_count !== 32'd1 || dut_vec !== exp_vec()) begin
         errs++; $display("FAIL rst_wait_setup got=%h exp=%h", dut_vec, exp_vec());
      end
      reset = 1'b1; tick(); reset = 1'b0;
      vecs++;
      if (dut_vec !== 40'd0) begin errs++; $display("FAIL rst_in_wait got=%h exp=0", dut_vec); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 99) == 0);
         enable      = ($urandom_range(0, 9) != 0);
         c1_alm_full = ($urandom_range(0, 4) == 0);
         sched_ready = ($urandom_range(0, 4) < 3);
         tx_done     = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 49) == 0) number_of_flows = 2'($urandom);
         if ($urandom_range(0, 99) == 0) l_batch_size = 2'($urandom);
         if ($urandom_range(0, 99) == 0) flush_timeout = 4'($urandom);
         if ($urandom_range(0, 9) == 0)
            flow_occupancy = pack($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
         tick();
         vecs++;
         if (dut_vec !== exp_vec()) begin errs++; $display("FAIL rand_cyc%0d got=%h exp=%h", i, dut_vec, exp_vec()); end
      end
   endtask

   initial begin
      test_reset();
      test_full_batch();
      test_round_robin();
      test_flush();
      test_alm_full();
      test_back_to_back_hold();
      test_reset_midgrant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
